// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants: instruction formats, major opcodes, the canonical NOP,
// and the encoder FSM state type.
package rv_pkg;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_LI  = 3'd6;
  localparam logic [2:0] FMT_RSV = 3'd7;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMIT1 = 2'd1,
    S_EMIT2 = 2'd2
  } enc_state_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I word builder.
// Scatters the immediate into the format's bit positions and flags immediates that are
// out of range or misaligned.
module imm_pack
  import rv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  // Signed-range checks: upper bits must all equal the sign bit of the field.
  logic fits12, fits13, fits21;
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    word = NOP;
    err  = 1'b1;
    unique case (fmt)
      FMT_R: begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
        err  = 1'b0;
      end
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        err  = ~fits12;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = ~fits12;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = imm[0] | ~fits13;
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        err  = |imm[11:0];
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = imm[0] | ~fits21;
      end
      default: begin
        word = NOP;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// RV32I instruction encoder with a valid/ready output stream.
// Load-immediate requests expand into LUI+ADDI when neither single-instruction form fits.
module imm_encoder
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic            out_last,
  output logic            out_err
);

  enc_state_t state_reg, state_next;
  logic [31:0] inst_reg, word2_reg;
  logic        last_reg, err_reg;

  logic [2:0]  pk_fmt;
  logic [6:0]  pk_opcode;
  logic [4:0]  pk_rs1;
  logic [2:0]  pk_funct3;
  logic [31:0] pk_imm;
  logic [31:0] pk_word;
  logic        pk_err;
  logic        two_word;
  logic        li_small, li_upper;
  logic [31:0] li_hi;
  logic [31:0] word2;
  logic        accept;

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg != S_IDLE);
  assign out_inst  = inst_reg;
  assign out_last  = last_reg;
  assign out_err   = err_reg;
  assign accept    = in_valid && in_ready;

  assign li_small = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign li_upper = ~(|in_imm[11:0]);
  // Rounding the upper part compensates for ADDI sign-extending its 12-bit immediate.
  assign li_hi    = in_imm + 32'h0000_0800;
  assign word2    = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM};

  always_comb begin
    pk_fmt    = in_fmt;
    pk_opcode = in_opcode;
    pk_rs1    = in_rs1;
    pk_funct3 = in_funct3;
    pk_imm    = in_imm;
    two_word  = 1'b0;
    if (in_fmt == FMT_LI) begin
      if (li_small) begin
        pk_fmt    = FMT_I;
        pk_opcode = OP_IMM;
        pk_rs1    = 5'd0;
        pk_funct3 = 3'd0;
      end else if (li_upper) begin
        pk_fmt    = FMT_U;
        pk_opcode = LUI;
      end else begin
        pk_fmt    = FMT_U;
        pk_opcode = LUI;
        pk_imm    = {li_hi[31:12], 12'h000};
        two_word  = 1'b1;
      end
    end
  end

  imm_pack u_pack (
    .fmt    (pk_fmt),
    .opcode (pk_opcode),
    .rd     (in_rd),
    .rs1    (pk_rs1),
    .rs2    (in_rs2),
    .funct3 (pk_funct3),
    .funct7 (in_funct7),
    .imm    (pk_imm),
    .word   (pk_word),
    .err    (pk_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (accept) state_next = S_EMIT1;
      S_EMIT1: if (out_ready) state_next = last_reg ? S_IDLE : S_EMIT2;
      S_EMIT2: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_reg  <= '0;
      word2_reg <= '0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      inst_reg  <= pk_word;
      word2_reg <= word2;
      last_reg  <= ~two_word;
      err_reg   <= pk_err;
    end else if (state_reg == S_EMIT1 && out_ready && !last_reg) begin
      inst_reg <= word2_reg;
      last_reg <= 1'b1;
      err_reg  <= 1'b0;
    end
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter: XLEN, default 32, instruction/immediate width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  request present.
REQ-005 Port: in_ready  output  1  encoder can accept a request.
REQ-006 Port: in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI (load-immediate pseudo), 7=reserved.
REQ-007 Port: in_opcode  input  7  opcode field; ignored for LI.
REQ-008 Port: in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-009 Port: in_funct3  input  3; in_funct7  input  7  function fields.
REQ-010 Port: in_imm  input  32  signed byte-offset or value immediate, unshifted.
REQ-011 Port: out_valid  output  1  encoded word present.
REQ-012 Port: out_ready  input  1  consumer accepts word.
REQ-013 Port: out_inst  output  32  encoded RV32I instruction word.
REQ-014 Port: out_last  output  1  word is the final word of the request.
REQ-015 Port: out_err  output  1  immediate out of range/misaligned or reserved fmt.

Function
REQ-016 States IDLE, EMIT1, EMIT2; in_ready SHALL equal (state==IDLE).
REQ-017 Accept on in_valid&&in_ready; all request fields SHALL be captured into registers at that edge; out_valid SHALL rise the following cycle (latency 1).
REQ-018 out_inst/out_last/out_err SHALL be registered and stable while out_valid&&!out_ready.
REQ-019 R: {funct7,rs2,rs1,funct3,rd,opcode}; in_imm ignored; out_err=0.
REQ-020 I: {imm[11:0],rs1,funct3,rd,opcode}; err if imm outside [-2048,2047].
REQ-021 S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; err as I.
REQ-022 B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; err if imm[0]=1 or outside [-4096,4094].
REQ-023 U: {imm[31:12],rd,opcode}; err if imm[11:0]!=0.
REQ-024 J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; err if imm[0]=1 or outside [-1048576,1048574].
REQ-025 On err the word SHALL still be emitted from truncated fields, single word, out_err=1.
REQ-026 LI, imm in [-2048,2047]: single ADDI rd,x0,imm (opcode 0010011, funct3 0), out_last=1.
REQ-027 LI, imm[11:0]==0: single LUI rd,imm[31:12] (opcode 0110111), out_last=1.
REQ-028 LI otherwise: EMIT1 LUI rd,hi with hi=(imm+0x800)[31:12] (32-bit wrap), out_last=0; EMIT2 ADDI rd,rd,imm[11:0], out_last=1; out_err=0.
REQ-029 Reserved fmt: emit 32'h00000013 (NOP), out_err=1, out_last=1.
REQ-030 Transitions: IDLE->EMIT1 on accept; EMIT1->EMIT2 on out_ready if two-word LI; EMIT1/EMIT2->IDLE on out_ready when out_last=1.
REQ-031 out_valid SHALL deassert the cycle after the final word handshake; no new accept in the same cycle (max throughput one request per two cycles).
REQ-032 in_* changes while in_ready=0 SHALL have no effect.

Reset
REQ-033 rst_n=0 at an edge SHALL force state=IDLE, out_valid=0, out_last=0, out_err=0, out_inst=0, discarding any in-flight request including a pending EMIT2 word.
REQ-034 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-035 Shared package rv_pkg SHALL hold the fmt encoding constants, opcode constants (OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP) and NOP constant.
REQ-036 One combinational sub-module imm_pack SHALL build word and range error from (fmt, fields, imm); the FSM and LI split stay in imm_encoder.

Verification
REQ-037 I: opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> out_inst 32'h00500093, out_last=1, out_err=0.
REQ-038 LI rd=5, imm=32'h12345FFF -> words 32'h123462B7 then 32'hFFF28293, out_last 0 then 1.
REQ-039 B opcode 1100011, rs1=1, rs2=2, funct3=0, imm=-4 -> 32'hFE208EE3; same with imm=3 -> out_err=1.
REQ-040 out_ready held low 3 cycles on an LI first word -> out_inst stable, in_ready=0, second word only after handshake.
REQ-041 rst_n low for one edge between LI words -> next cycle out_valid=0, in_ready=1, second word never emitted.
REQ-042 in_fmt=7 -> 32'h00000013 with out_err=1.
